// File: rtl/uart_rs232_rx.sv
// RS-232 style UART receiver: 16x oversampled, 1..8 data bits, one stop bit.
// Holds the last good frame until acknowledged and reports framing and overrun errors.
module uart_rs232_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Tick,
    input  logic       RxEn,
    input  logic       Rx,
    input  logic [3:0] NBits,
    input  logic       RxAck,
    output logic [7:0] RxData,
    output logic       RxDone,
    output logic       RxValid,
    output logic       FrameErr,
    output logic       Overrun
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                 state, state_next;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic [3:0]             tick_cnt;
    logic [3:0]             bit_idx;
    logic [3:0]             nbits_q;
    logic [3:0]             nbits_eff;
    logic                   armed;
    logic [7:0]             shift_q;
    logic                   go_start;
    logic                   go_data;
    logic                   shift_en;
    logic                   frame_good;
    logic                   frame_bad;
    logic                   last_bit;

    // Rx is asynchronous to Clk; the chain resets to the idle (high) level.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], Rx};
        end
    end

    assign rx_s      = sync_q[SYNC_STAGES-1];
    assign nbits_eff = ((NBits == 4'd0) || (NBits > 4'd8)) ? 4'd8 : NBits;
    assign last_bit  = (bit_idx == (nbits_q - 4'd1));

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Dropping RxEn aborts immediately, independent of Tick.
    always_comb begin
        state_next = state;
        go_start   = 1'b0;
        go_data    = 1'b0;
        shift_en   = 1'b0;
        frame_good = 1'b0;
        frame_bad  = 1'b0;
        if ((state != IDLE) && !RxEn) begin
            state_next = IDLE;
        end else if (Tick) begin
            unique case (state)
                IDLE: begin
                    if (RxEn && !rx_s && armed) begin
                        state_next = START;
                        go_start   = 1'b1;
                    end
                end
                START: begin
                    if (tick_cnt == 4'd7) begin
                        if (!rx_s) begin
                            state_next = DATA;
                            go_data    = 1'b1;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
                DATA: begin
                    if (tick_cnt == 4'd15) begin
                        shift_en = 1'b1;
                        if (last_bit) begin
                            state_next = STOP;
                        end
                    end
                end
                STOP: begin
                    if (tick_cnt == 4'd15) begin
                        state_next = IDLE;
                        frame_good = rx_s;
                        frame_bad  = !rx_s;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // A framing error disarms so that a held break cannot look like a new start bit.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            tick_cnt <= 4'd0;
            bit_idx  <= 4'd0;
            nbits_q  <= 4'd8;
            armed    <= 1'b0;
            shift_q  <= 8'h00;
        end else begin
            if (Tick) begin
                tick_cnt <= (go_start || go_data) ? 4'd0 : tick_cnt + 4'd1;
            end
            if (go_start) begin
                nbits_q <= nbits_eff;
                shift_q <= 8'h00;
            end
            if (go_data) begin
                bit_idx <= 4'd0;
            end else if (shift_en) begin
                shift_q[bit_idx[2:0]] <= rx_s;
                bit_idx               <= bit_idx + 4'd1;
            end
            if (go_start || frame_bad) begin
                armed <= 1'b0;
            end else if (Tick && rx_s) begin
                armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            RxData   <= 8'h00;
            RxDone   <= 1'b0;
            RxValid  <= 1'b0;
            FrameErr <= 1'b0;
            Overrun  <= 1'b0;
        end else begin
            RxDone <= frame_good;
            if (frame_good) begin
                RxData   <= shift_q;
                FrameErr <= 1'b0;
            end else if (frame_bad) begin
                FrameErr <= 1'b1;
            end
            if (frame_good) begin
                RxValid <= 1'b1;
            end else if (RxAck) begin
                RxValid <= 1'b0;
            end
            if (RxAck) begin
                Overrun <= 1'b0;
            end else if (frame_good && RxValid) begin
                Overrun <= 1'b1;
            end
        end
    end

endmodule
